demux_1to8_reg: RTL and testbench
=================================

Name: demux_1to8_reg

Overview:
- Registered 1-to-8 demultiplexer. Routes a single data bit `din` to one of eight output lanes selected by a 3-bit `sel`.
- All non-selected lanes are driven to 0.
- Outputs are updated on the rising clock edge, gated by `enable`.
- Used as a lane-steering stage in front of per-lane consumers; adds an invalid-select flag for robustness in simulation and at integration.

Parameters:
- N_OUT, 8, number of output lanes; fixed at 8, since `sel` is 3 bits.
- SEL_W, 3, select width, equal to log2(N_OUT).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high. Clears all registered outputs immediately.
- enable  input  1  when 1, update outputs from `sel`/`din`; when 0, clear outputs.
- sel  input  3  lane index, 0..7.
- din  input  1  data bit to route.
- douts  output  8  registered lane outputs; `douts[i]` is lane i.
- sel_err  output  1  registered flag; 1 when the last enabled sample had an unresolvable `sel`.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: while `rst`=1, `douts`=8'h00 and `sel_err`=0, independent of `clk`. The first update after release is on the first rising `clk` edge with `rst`=0.
- Latency: 1 cycle. Outputs reflect the inputs sampled at the previous rising edge. There is no combinational path from inputs to outputs.
- At each rising `clk` edge with `rst`=0:
  - `enable`=0: `douts` <= 8'h00, `sel_err` <= 0.
  - `enable`=1 and `sel` a legal value k (0..7): `douts` <= bit k = `din`, all other bits 0; `sel_err` <= 0.
  - `enable`=1 and `sel` containing any X or Z bit (simulation only): `douts` <= 8'h00, `sel_err` <= 1. Implement this as the default branch of a full case on `sel`; in synthesis the branch is unreachable and `sel_err` is constant 0.
  - `enable` X/Z (simulation): treat as 0.
- `din`=0 with a valid `sel`: `douts`=8'h00. This is legal and distinct from an error; `sel_err`=0.
- At most one bit of `douts` is 1 at any time (one-hot or zero).
- `sel` changing every cycle: each cycle's output depends only on that cycle's sample; there is no hold-over from the previous lane.
- Reset asserted mid-operation: outputs clear asynchronously. There is no other state to recover.

Decomposition:
- Shared package `demux_pkg`:
  - constants N_OUT=8 and SEL_W=3.
  - typedef `lane_sel_t` (logic [SEL_W-1:0]).
  - typedef `lanes_t` (logic [N_OUT-1:0]).
- One natural combinational sub-module, `onehot_dec3to8`. It takes `sel`, `din` and `en`, and returns next-state `lanes_t` plus an invalid flag.
- The top module holds only the two output registers and the async reset.

Test Plan:
- Reset: assert `rst`=1 with `enable`=1, `sel`=3'b101, `din`=1 -> `douts`=8'h00 and `sel_err`=0 immediately, without waiting for a clock edge. After release plus one edge -> `douts`=8'h20.
- Valid routing sweep: `enable`=1, `din`=1, `sel` stepping 0,2,7 on consecutive edges -> `douts`=8'h01, 8'h04, 8'h80, each one cycle after the sample.
- din=0 / enable low: `enable`=1, `din`=0, `sel`=3'b010 -> `douts`=8'h00, `sel_err`=0. Then `enable`=0, `din`=1, `sel`=3'b000 -> `douts`=8'h00.
- Invalid select (simulation): `enable`=1, `din`=1, `sel`=3'bzzz, then 3'bxxx -> `douts`=8'h00 and `sel_err`=1 for both. Then `sel`=3'b101&3'b010 (=3'b000) -> `douts`=8'h01, `sel_err`=0.
- Corner re-enable: `enable`=0 with `sel`=0 for one cycle, then `enable`=1 with `sel`=3'b111, `din`=1 -> `douts` 8'h00 then 8'h80; assert one-hot-or-zero on every cycle.
- Random: 200 cycles of random `enable`/`sel`/`din` with `rst` pulses, checked against a reference model of the rules above.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-8 lane demultiplexer.
// No latency or backpressure of its own; types only.
package demux_pkg;
  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;
  typedef logic [N_OUT-1:0] lanes_t;
endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational lane decoder: routes din_i to lane sel_i when en_i, flags unresolvable selects.
// Zero latency; no backpressure (pure function of its inputs).
module onehot_dec3to8
  import demux_pkg::*;
(
  input  lane_sel_t sel_i,
  input  logic      din_i,
  input  logic      en_i,
  output lanes_t    lanes_o,
  output logic      err_o
);

  always_comb begin
    lanes_o = '0;
    err_o   = 1'b0;
    // An X/Z enable falls through to the disabled branch.
    if (en_i) begin
      case (sel_i)
        3'd0: lanes_o[0] = din_i;
        3'd1: lanes_o[1] = din_i;
        3'd2: lanes_o[2] = din_i;
        3'd3: lanes_o[3] = din_i;
        3'd4: lanes_o[4] = din_i;
        3'd5: lanes_o[5] = din_i;
        3'd6: lanes_o[6] = din_i;
        3'd7: lanes_o[7] = din_i;
        // Reached only when sel carries X/Z; unreachable after synthesis.
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demux: one cycle from sample to douts/sel_err, async active-high clear.
// No backpressure: every rising edge overwrites the outputs.
module demux_1to8_reg
  import demux_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  lane_sel_t sel,
  input  logic      din,
  output lanes_t    douts,
  output logic      sel_err
);

  lanes_t douts_d, douts_q;
  logic   sel_err_d, sel_err_q;

  onehot_dec3to8 u_dec (
    .sel_i   (sel),
    .din_i   (din),
    .en_i    (enable),
    .lanes_o (douts_d),
    .err_o   (sel_err_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douts_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      douts_q   <= douts_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign douts   = douts_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Scoreboard bench for demux_1to8_reg: directed corners plus random traffic with reset pulses.
module tb_demux_1to8_reg;

  typedef struct packed {
    logic [7:0] lanes;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       din = 1'b0;
  logic [7:0] douts;
  logic       sel_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  demux_1to8_reg dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .sel     (sel),
    .din     (din),
    .douts   (douts),
    .sel_err (sel_err)
  );

  always #5 clk = ~clk;

  // Reference: reset or disable clears; unknown select flags; otherwise din lands on lane sel.
  function automatic exp_t model(logic r, logic e, logic [2:0] s, logic d);
    exp_t x;
    x.lanes = 8'h00;
    x.err   = 1'b0;
    if (r === 1'b1 || e !== 1'b1) return x;
    if ($isunknown(s)) begin
      x.err = 1'b1;
      return x;
    end
    if (d === 1'b1) x.lanes = 8'(1 << int'(s));
    return x;
  endfunction

  task automatic check(string name, exp_t want);
    n_tests++;
    if (douts !== want.lanes || sel_err !== want.err) begin
      n_fail++;
      $display("FAIL %s: got douts=%h sel_err=%b, want douts=%h sel_err=%b",
               name, douts, sel_err, want.lanes, want.err);
    end
  endtask

  task automatic drive(logic r, logic e, logic [2:0] s, logic d);
    @(negedge clk);
    rst    = r;
    enable = e;
    sel    = s;
    din    = d;
    exp_q.push_back(model(rst, enable, sel, din));
  endtask

  // Monitor: every cycle the outputs are a fresh registered result.
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      n_tests++;
      if (!$onehot0(douts)) begin
        n_fail++;
        $display("FAIL onehot0: got douts=%h, want at most one bit set", douts);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("scoreboard", want);
      end
    end
  end

  initial begin
    exp_t zero;
    zero = '0;
    #1;
    check("reset_state", zero);

    // Prime a nonzero output, then assert reset between edges.
    drive(1'b0, 1'b1, 3'd3, 1'b1);
    drive(1'b0, 1'b1, 3'd3, 1'b1);
    #1;
    check("primed_lane3", exp_t'({8'h08, 1'b0}));
    drive(1'b1, 1'b1, 3'b101, 1'b1);
    #1;
    check("async_reset", zero);
    drive(1'b0, 1'b1, 3'b101, 1'b1);

    // Routing sweep.
    drive(1'b0, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 3'd2, 1'b1);
    drive(1'b0, 1'b1, 3'd7, 1'b1);

    // din=0 and enable low.
    drive(1'b0, 1'b1, 3'b010, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 1'b1);

    // Unresolvable selects, then recovery.
    drive(1'b0, 1'b1, 3'bxxx, 1'b1);
    drive(1'b0, 1'b1, 3'b1x0, 1'b1);
    drive(1'b0, 1'b1, 3'b101 & 3'b010, 1'b1);

    // Re-enable corner.
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    drive(1'b0, 1'b1, 3'b111, 1'b1);

    // Unknown enable behaves as disabled.
    drive(1'b0, 1'bx, 3'd4, 1'b1);

    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 3'($urandom), 1'($urandom));
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
